// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: FSM states, the response bundle and
// a helper that sizes the ACCESS-stall counter from a timeout limit.
package apb_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        timeout;
   } rsp_t;

   localparam int DEF_TIMEOUT_CYCLES = 255;

   // A disabled timeout (0) still needs a 1-bit counter to keep the logic legal.
   function automatic int cnt_width(input int timeout_cycles);
      return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
   endfunction

   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// APB3 bus between a single requester and its completer segment.
interface apb_cmd_master_if #(
   parameter int ADDR_WIDTH = 12
) ();

   logic [ADDR_WIDTH-1:0] PADDR;
   logic [31:0]           PWDATA;
   logic                  PWRITE;
   logic                  PSEL;
   logic                  PENABLE;
   logic [31:0]           PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into single APB3 transfers, one at a time,
// with misalignment rejection and a completer-stall timeout.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [31:0]               cmd_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic                      busy_o,
   apb_cmd_master_if.master          apb
);

   localparam int              CNT_W   = cnt_width(TIMEOUT_CYCLES);
   localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e                    state_q, state_d;
   rsp_t                      rsp_q, rsp_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;

   // All state lives here; reset returns the bus to idle immediately.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= IDLE;
         rsp_q    <= '0;
         cnt_q    <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rsp_q    <= rsp_d;
         cnt_q    <= cnt_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rsp_d    = rsp_q;
      cnt_d    = cnt_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               if (!is_word_aligned(cmd_addr_i[1:0])) begin
                  // Misaligned commands are answered without touching the bus.
                  rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b0};
                  state_d = RESP;
               end else begin
                  paddr_d  = cmd_addr_i;
                  pwdata_d = cmd_wdata_i;
                  pwrite_d = cmd_write_i;
                  cnt_d    = '0;
                  state_d  = SETUP;
               end
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            if (apb.PREADY) begin
               rsp_d   = '{rdata: (pwrite_q ? 32'h0 : apb.PRDATA),
                           err: apb.PSLVERR, timeout: 1'b0};
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               // Abandoning the transfer breaks APB, but is the only way out of a hung completer.
               if (TO_EN && (cnt_q == TO_LAST)) begin
                  rsp_d   = '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
                  state_d = RESP;
               end
            end
         end

         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready_o   = (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_rdata_o   = rsp_q.rdata;
   assign rsp_err_o     = rsp_q.err;
   assign rsp_timeout_o = rsp_q.timeout;

   assign apb.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
   assign apb.PENABLE = (state_q == ACCESS);
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign apb.PWRITE  = pwrite_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench: APB completer BFM with wait states, PSLVERR and hang,
// plus a transaction-level reference model of responses, latency and memory.
module tb_apb_cmd_master;
   import apb_cmd_pkg::*;

   localparam int AW = 12;
   localparam int TO = 8;

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          busy;

   apb_cmd_master_if #(.ADDR_WIDTH(AW)) apb ();

   apb_cmd_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .cmd_valid_i   (cmd_valid),
      .cmd_ready_o   (cmd_ready),
      .cmd_write_i   (cmd_write),
      .cmd_addr_i    (cmd_addr),
      .cmd_wdata_i   (cmd_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .rsp_timeout_o (rsp_timeout),
      .busy_o        (busy),
      .apb           (apb.master)
   );

   always #5 HCLK = ~HCLK;

   int vectors     = 0;
   int miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Completer BFM: answers after bfm_waits stalled ACCESS cycles unless hung.
   int          bfm_waits = 0;
   bit          bfm_err   = 1'b0;
   bit          bfm_hang  = 1'b0;
   int          bfm_access = 0;
   logic [31:0] bfm_mem   [1024];
   logic [31:0] model_mem [1024];
   logic [AW-1:0] last_paddr = '0;

   function automatic logic [31:0] default_word(input int idx);
      return 32'hA500_0000 | 32'(idx);
   endfunction

   always @(negedge HCLK) begin
      if (apb.PSEL && apb.PENABLE) begin
         if (!bfm_hang && bfm_access == bfm_waits) begin
            apb.PREADY  = 1'b1;
            apb.PSLVERR = bfm_err;
            apb.PRDATA  = apb.PWRITE ? $urandom : bfm_mem[int'(apb.PADDR[AW-1:2])];
            if (apb.PWRITE && !bfm_err) bfm_mem[int'(apb.PADDR[AW-1:2])] = apb.PWDATA;
         end else begin
            apb.PREADY  = 1'b0;
            apb.PSLVERR = 1'($urandom);
            apb.PRDATA  = $urandom;
         end
         bfm_access++;
      end else begin
         bfm_access  = 0;
         apb.PREADY  = 1'b0;
         apb.PSLVERR = 1'b0;
         apb.PRDATA  = $urandom;
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".ctl"},
                  32'({apb.PSEL, apb.PENABLE, apb.PWRITE, rsp_valid, rsp_err, rsp_timeout, busy, cmd_ready}),
                  32'h01);
      checkOutput({tag, ".paddr"},  32'(apb.PADDR), 32'h0);
      checkOutput({tag, ".pwdata"}, apb.PWDATA, 32'h0);
      checkOutput({tag, ".rdata"},  rsp_rdata, 32'h0);
   endtask

   task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                input int waits, input bit slv_err, input bit hang, input int stall,
                                input string tag);
      bit          aligned;
      bit          exp_err, exp_to;
      logic [31:0] exp_rdata;
      int          exp_lat, exp_acc, exp_psel;
      int          cycles, psel_cnt, acc_cnt, bad_cnt;
      int          idx;

      aligned = (addr[1:0] == 2'b00);
      idx     = int'(addr[AW-1:2]);
      if (!aligned) begin
         exp_err = 1'b1; exp_to = 1'b0; exp_rdata = 32'h0; exp_lat = 1; exp_acc = 0;
      end else if (hang) begin
         exp_err = 1'b1; exp_to = 1'b1; exp_rdata = 32'h0; exp_lat = 2 + TO; exp_acc = TO;
      end else begin
         exp_err = slv_err; exp_to = 1'b0;
         exp_rdata = wr ? 32'h0 : model_mem[idx];
         exp_lat = 3 + waits; exp_acc = 1 + waits;
         if (wr && !slv_err) model_mem[idx] = wdata;
      end
      exp_psel = aligned ? exp_acc + 1 : 0;

      @(negedge HCLK);
      bfm_waits = waits; bfm_err = slv_err; bfm_hang = hang;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; rsp_ready = 1'b0;
      checkOutput({tag, ".cmd_ready"}, 32'(cmd_ready), 32'h1);

      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      cycles = 1; psel_cnt = 0; acc_cnt = 0; bad_cnt = 0;
      while (!rsp_valid && cycles < 40) begin
         if (apb.PSEL) begin
            psel_cnt++;
            if (apb.PENABLE) acc_cnt++;
            if (apb.PADDR !== addr || apb.PWRITE !== wr || apb.PWDATA !== wdata) bad_cnt++;
         end
         @(posedge HCLK); #1;
         cycles++;
      end
      if (aligned) last_paddr = addr;

      checkOutput({tag, ".latency"},  32'(cycles), 32'(exp_lat));
      checkOutput({tag, ".psel_cyc"}, 32'(psel_cnt), 32'(exp_psel));
      checkOutput({tag, ".acc_cyc"},  32'(acc_cnt), 32'(exp_acc));
      checkOutput({tag, ".bus_stable"}, 32'(bad_cnt), 32'h0);
      checkOutput({tag, ".paddr_hold"}, 32'(apb.PADDR), 32'(last_paddr));
      checkOutput({tag, ".rsp"}, 32'({rsp_valid, rsp_err, rsp_timeout, busy, cmd_ready, apb.PSEL}),
                  32'({1'b1, exp_err, exp_to, 1'b1, 1'b0, 1'b0}));
      checkOutput({tag, ".rdata"}, rsp_rdata, exp_rdata);

      // Stall the response while offering a competing command that must be ignored.
      for (int s = 0; s < stall; s++) begin
         cmd_valid = 1'b1; cmd_write = 1'b1;
         cmd_addr = AW'($urandom_range(0, 63) * 4); cmd_wdata = $urandom;
         @(posedge HCLK); #1;
         checkOutput({tag, ".stall_rsp"}, 32'({rsp_valid, rsp_err, rsp_timeout, cmd_ready}),
                     32'({1'b1, exp_err, exp_to, 1'b0}));
         checkOutput({tag, ".stall_rdata"}, rsp_rdata, exp_rdata);
      end

      @(negedge HCLK);
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge HCLK); #1;
      rsp_ready = 1'b0;
      checkOutput({tag, ".release"}, 32'({rsp_valid, busy, cmd_ready}), 32'b001);
   endtask

   initial begin
      bit            wr, er, hg;
      logic [AW-1:0] addr;
      int            waits;

      for (int i = 0; i < 1024; i++) begin
         bfm_mem[i]   = default_word(i);
         model_mem[i] = default_word(i);
      end
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge HCLK);
      checkResetState("reset");
      HRESETn = 1'b1;

      applyStimulus(1'b1, 12'h004, 32'h1C00_8080, 0, 1'b0, 1'b0, 0, "t1_wr");
      applyStimulus(1'b0, 12'h004, 32'h0000_0000, 0, 1'b0, 1'b0, 0, "t1_rd");
      applyStimulus(1'b0, 12'h070, 32'h5555_0000, 3, 1'b0, 1'b0, 0, "t2_wait");
      applyStimulus(1'b0, 12'h0C0, 32'h0000_1111, 0, 1'b1, 1'b0, 0, "t3_slverr");
      applyStimulus(1'b1, 12'h0C4, 32'h0BAD_0BAD, 1, 1'b1, 1'b0, 0, "t3_wr_slverr");
      applyStimulus(1'b0, 12'h0C4, 32'h0000_0000, 0, 1'b0, 1'b0, 0, "t3_rd_back");
      applyStimulus(1'b0, 12'h010, 32'h0000_2222, 0, 1'b0, 1'b1, 0, "t4_hang");
      applyStimulus(1'b0, 12'h004, 32'h0000_3333, 0, 1'b0, 1'b0, 0, "t4_next");
      applyStimulus(1'b1, 12'h062, 32'h0000_DEAD, 0, 1'b0, 1'b0, 0, "t5_misalign");
      applyStimulus(1'b1, 12'h008, 32'h1234_5678, 1, 1'b0, 1'b0, 5, "t6_stall");

      // Reset in the middle of a stalled ACCESS phase.
      @(negedge HCLK);
      bfm_hang = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'hFFFF_0001;
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      waits = 0;
      while (!apb.PENABLE && waits < 5) begin
         @(posedge HCLK); #1;
         waits++;
      end
      checkOutput("t6_in_access", 32'(apb.PENABLE), 32'h1);
      #2 HRESETn = 1'b0;
      #1 checkResetState("t6_reset");
      @(negedge HCLK);
      HRESETn = 1'b1;
      last_paddr = '0;
      applyStimulus(1'b0, 12'h008, 32'h0000_0000, 0, 1'b0, 1'b0, 0, "t6_after");

      for (int n = 0; n < 40; n++) begin
         wr    = 1'($urandom_range(0, 1));
         addr  = AW'(12'h100 + $urandom_range(0, 15) * 4);
         if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         waits = $urandom_range(0, 3);
         er    = ($urandom_range(0, 6) == 0);
         hg    = ($urandom_range(0, 19) == 0);
         applyStimulus(wr, addr, $urandom, waits, er, hg, $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
